// File: rtl/piso_encoder_pkg.sv
// Shared framing constants for the serial message link; imported by both the
// transmit encoder and the receive-side decoder so both ends agree on framing.
package piso_encoder_pkg;

  localparam int unsigned MSG_WIDTH = 8;
  localparam logic [MSG_WIDTH-1:0] IDLE_WORD_DEFAULT = 8'h00;
  localparam bit LSB_FIRST = 1'b1;
  localparam int unsigned FRAMES_SENT_W = 16;

  function automatic logic [FRAMES_SENT_W-1:0] sat_inc(input logic [FRAMES_SENT_W-1:0] value);
    return (value == '1) ? value : value + FRAMES_SENT_W'(1);
  endfunction

endpackage

// File: rtl/piso_encoder_frame_bit_counter.sv
// Modulo-WIDTH framing counter; transmit-side twin of the decoder's bit counter.
// Resets to the last bit position so the first edge after release is a load.
module piso_encoder_frame_bit_counter
  import piso_encoder_pkg::*;
#(
  parameter int unsigned WIDTH = MSG_WIDTH,
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clock,
  input  logic             resetN,
  output logic [IDX_W-1:0] bit_idx,
  output logic             load
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;

  assign load    = (bit_idx_q == LAST_IDX);
  assign bit_idx = bit_idx_q;

  always_comb begin
    bit_idx_d = load ? '0 : bit_idx_q + IDX_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      bit_idx_q <= LAST_IDX;
    end else begin
      bit_idx_q <= bit_idx_d;
    end
  end

endmodule

// File: rtl/piso_encoder.sv
// Parallel-in serial-out message encoder: one-entry holding register feeding a
// continuously framed shift register; idle frames keep the receiver aligned.
module piso_encoder
  import piso_encoder_pkg::*;
#(
  parameter int unsigned      WIDTH     = MSG_WIDTH,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(IDLE_WORD_DEFAULT)
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic [WIDTH-1:0]         messageIn,
  input  logic                     messageValid,
  output logic                     messageReady,
  output logic                     serialOut,
  output logic                     frameSync,
  output logic                     dataFrame,
  output logic [FRAMES_SENT_W-1:0] framesSent
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [IDX_W-1:0] bit_idx;
  logic             load_event;
  logic             accept;

  logic [WIDTH-1:0]         shift_q, shift_d;
  logic [WIDTH-1:0]         hold_q, hold_d;
  logic                     hold_valid_q, hold_valid_d;
  logic                     data_frame_q, data_frame_d;
  logic [FRAMES_SENT_W-1:0] frames_sent_q, frames_sent_d;

  piso_encoder_frame_bit_counter #(
    .WIDTH (WIDTH)
  ) u_frame_bit_counter (
    .clock   (clock),
    .resetN  (resetN),
    .bit_idx (bit_idx),
    .load    (load_event)
  );

  // A load frees the holding slot on the same edge, so a new word can enter then.
  assign messageReady = !hold_valid_q || load_event;
  assign accept       = messageValid && messageReady;

  always_comb begin
    shift_d       = shift_q;
    hold_d        = hold_q;
    hold_valid_d  = hold_valid_q;
    data_frame_d  = data_frame_q;
    frames_sent_d = frames_sent_q;

    if (load_event) begin
      hold_valid_d = 1'b0;
      if (hold_valid_q) begin
        shift_d       = hold_q;
        data_frame_d  = 1'b1;
        frames_sent_d = sat_inc(frames_sent_q);
      end else begin
        shift_d      = IDLE_WORD;
        data_frame_d = 1'b0;
      end
    end else begin
      shift_d = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
    end

    if (accept) begin
      hold_d       = messageIn;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      shift_q       <= '0;
      hold_q        <= '0;
      hold_valid_q  <= 1'b0;
      data_frame_q  <= 1'b0;
      frames_sent_q <= '0;
    end else begin
      shift_q       <= shift_d;
      hold_q        <= hold_d;
      hold_valid_q  <= hold_valid_d;
      data_frame_q  <= data_frame_d;
      frames_sent_q <= frames_sent_d;
    end
  end

  assign serialOut  = LSB_FIRST ? shift_q[0] : shift_q[WIDTH-1];
  assign frameSync  = (bit_idx == '0);
  assign dataFrame  = data_frame_q;
  assign framesSent = frames_sent_q;

endmodule

// File: tb/tb_piso_encoder.sv
// Scoreboard bench for piso_encoder: accepted words are queued, and a monitor
// rebuilds every serial frame and checks framing, handshake and counters.
module tb_piso_encoder;

  localparam int W = 8;
  localparam logic [W-1:0] IDLE = 8'h00;

  logic         clock;
  logic         resetN;
  logic [W-1:0] messageIn;
  logic         messageValid;
  logic         messageReady;
  logic         serialOut;
  logic         frameSync;
  logic         dataFrame;
  logic [15:0]  framesSent;

  int n_tests = 0;
  int n_fail  = 0;

  piso_encoder dut (
    .clock        (clock),
    .resetN       (resetN),
    .messageIn    (messageIn),
    .messageValid (messageValid),
    .messageReady (messageReady),
    .serialOut    (serialOut),
    .frameSync    (frameSync),
    .dataFrame    (dataFrame),
    .framesSent   (framesSent)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model state: words accepted but not yet started, frame phase
  // counted in cycles since reset release, and the expected data-frame count.
  logic [W-1:0] exp_q[$];
  int           phase = -1;
  bit           prev_rst_low = 1'b0;
  int           load_pending = 0;
  bit           cur_data = 1'b0;
  logic [W-1:0] cur_exp = '0;
  logic [W-1:0] frame_word = '0;
  logic [15:0]  cnt = '0;

  always @(negedge clock) begin
    int  bi;
    bit  ready_exp;
    if (prev_rst_low) begin
      check("rst_serialOut", 32'(serialOut), 32'd0);
      check("rst_frameSync", 32'(frameSync), 32'd0);
      check("rst_messageReady", 32'(messageReady), 32'd1);
      check("rst_dataFrame", 32'(dataFrame), 32'd0);
      check("rst_framesSent", 32'(framesSent), 32'd0);
    end
    if (!resetN) begin
      exp_q.delete();
      cnt          = '0;
      phase        = -1;
      load_pending = 0;
      prev_rst_low = 1'b1;
    end else begin
      if (prev_rst_low) phase = 0;
      else if (phase >= 0) phase++;
      prev_rst_low = 1'b0;
      if (phase >= 0) begin
        check("frameSync", 32'(frameSync), 32'(phase % W == 1));
        if (phase >= 1) begin
          bi = (phase - 1) % W;
          if (bi == 0) begin
            cur_data = (load_pending > 0);
            if (cur_data) begin
              cur_exp = exp_q.pop_front();
              if (cnt != 16'hFFFF) cnt++;
            end else begin
              cur_exp = IDLE;
            end
          end
          frame_word[bi] = serialOut;
          check("dataFrame", 32'(dataFrame), 32'(cur_data));
          if (bi == W - 1) check(cur_data ? "data_word" : "idle_word", 32'(frame_word),
                                 32'(cur_exp));
        end
        check("framesSent", 32'(framesSent), 32'(cnt));
        ready_exp = (exp_q.size() == 0) || (phase % W == 0);
        check("messageReady", 32'(messageReady), 32'(ready_exp));
        load_pending = exp_q.size();
        if (messageValid && ready_exp) exp_q.push_back(messageIn);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w);
    int n;
    messageIn    = w;
    messageValid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!messageReady && n < 40) begin
      n++;
      @(negedge clock);
    end
    check("send_accept", 32'(messageReady), 32'd1);
    @(posedge clock);
    #1;
    messageValid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    resetN       = 1'b0;
    messageValid = 1'b0;
    idle(n);
    resetN = 1'b1;
  endtask

  initial begin
    int n;
    resetN       = 1'b0;
    messageValid = 1'b0;
    messageIn    = '0;
    idle(3);
    resetN = 1'b1;
    idle(40);

    // Single word a few cycles into the first frame.
    do_reset(2);
    idle(3);
    send(8'hA5);
    idle(20);

    // Two words presented back-to-back: second accepted on the load edge.
    send(8'h3C);
    send(8'hC3);
    idle(24);

    for (int i = 1; i <= 16; i++) send(W'(i));
    idle(20);

    // Reset at bit 3 of a data frame while another word is held.
    send(8'h5A);
    messageIn    = 8'hFF;
    messageValid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!(frameSync && dataFrame) && n < 40) begin
      n++;
      @(negedge clock);
    end
    check("reset_frame_found", 32'(frameSync && dataFrame), 32'd1);
    idle(3);
    do_reset(2);
    idle(20);

    for (int i = 0; i < 200; i++) begin
      idle($urandom_range(0, 20));
      send(W'($urandom));
    end
    idle(20);

    // Counter saturation, preloaded just below the limit.
    force dut.frames_sent_q = 16'hFFFE;
    #1;
    release dut.frames_sent_q;
    cnt = 16'hFFFE;
    send(8'h11);
    send(8'h22);
    send(8'h33);
    idle(40);
    check("sat_final", 32'(framesSent), 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
